// File: rtl/csr_pkg.sv
// Shared funct3/FSM types and counter addresses for the CSR access unit.
package csr_pkg;

    typedef enum logic [2:0] {
        F3Rw  = 3'b001,
        F3Rs  = 3'b010,
        F3Rc  = 3'b011,
        F3Rwi = 3'b101,
        F3Rsi = 3'b110,
        F3Rci = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    localparam logic [11:0] CSR_CYCLE  = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH = 12'hC80;

endpackage

// File: rtl/csr_access_unit_if.sv
// Request, response and CSR-file port of the CSR access unit.
// The master side is the pipeline plus CSR file; the slave side is the unit.
interface csr_access_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_funct3;
    logic [11:0]     req_addr;
    logic [4:0]      req_rs1;
    logic [XLEN-1:0] req_rs1_val;
    logic [4:0]      req_rd;

    logic            resp_valid;
    logic            resp_ready;
    logic [4:0]      resp_rd;
    logic [XLEN-1:0] resp_data;
    logic            resp_illegal;

    logic            csr_we;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;

    modport master (
        output req_valid, req_funct3, req_addr, req_rs1, req_rs1_val, req_rd,
        input  req_ready,
        input  resp_valid, resp_rd, resp_data, resp_illegal,
        output resp_ready,
        input  csr_we, csr_addr, csr_wdata,
        output csr_rdata
    );

    modport slave (
        input  req_valid, req_funct3, req_addr, req_rs1, req_rs1_val, req_rd,
        output req_ready,
        output resp_valid, resp_rd, resp_data, resp_illegal,
        input  resp_ready,
        output csr_we, csr_addr, csr_wdata,
        input  csr_rdata
    );

endinterface

// File: rtl/csr_alu.sv
// Zicsr read-modify-write datapath: new CSR value and write-suppress flag.
module csr_alu
    import csr_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [4:0]      rs1,
    input  logic [XLEN-1:0] old_val,
    input  logic [XLEN-1:0] src,
    output logic [XLEN-1:0] new_val,
    output logic            suppress
);

    always_comb begin
        new_val  = old_val;
        suppress = 1'b1;
        case (funct3)
            F3Rw, F3Rwi: begin
                new_val  = src;
                suppress = 1'b0;
            end
            F3Rs, F3Rsi: begin
                new_val  = old_val | src;
                suppress = (rs1 == 5'd0);
            end
            F3Rc, F3Rci: begin
                new_val  = old_val & ~src;
                suppress = (rs1 == 5'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/csr_access_unit.sv
// Zicsr initiator: one atomic CSR read-modify-write per request, old value to writeback.
// Optional read-only 64-bit cycle counter at 0xC00/0xC80 when CSR_CYCLE_COUNTER_EN is defined.
module csr_access_unit
    import csr_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NCSR = 11
) (
    input logic              clk,
    input logic              rst_n,
    csr_access_unit_if.slave bus
);

    state_e          state_q;
    logic [2:0]      funct3_q;
    logic [11:0]     addr_q;
    logic [4:0]      rs1_q;
    logic [XLEN-1:0] rs1_val_q;
    logic [4:0]      rd_q;

    logic            req_ready_q;
    logic            resp_valid_q;
    logic [4:0]      resp_rd_q;
    logic [XLEN-1:0] resp_data_q;
    logic            resp_illegal_q;

    logic            exec;
    logic [XLEN-1:0] src;
    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] new_val;
    logic [XLEN-1:0] counter_val;
    logic            suppress;
    logic            is_counter;
    logic            addr_oob;
    logic            illegal;
    logic            csr_we;

    assign exec = (state_q == StExec);
    assign src  = funct3_q[2] ? XLEN'(rs1_q) : rs1_val_q;

`ifdef CSR_CYCLE_COUNTER_EN
    logic [63:0] cycle_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 64'd1;
        end
    end

    assign is_counter  = (addr_q == CSR_CYCLE) || (addr_q == CSR_CYCLEH);
    assign counter_val = (addr_q == CSR_CYCLEH) ? XLEN'(cycle_q[63:32]) : XLEN'(cycle_q[31:0]);
`else
    assign is_counter  = 1'b0;
    assign counter_val = '0;
`endif

    assign old_val  = is_counter ? counter_val : bus.csr_rdata;
    assign addr_oob = ({20'd0, addr_q} >= NCSR);

    csr_alu #(
        .XLEN(XLEN)
    ) u_alu (
        .funct3  (funct3_q),
        .rs1     (rs1_q),
        .old_val (old_val),
        .src     (src),
        .new_val (new_val),
        .suppress(suppress)
    );

    // Counters are read-only: any op that would write them is illegal.
    assign illegal = (funct3_q[1:0] == 2'b00) || (addr_oob && !is_counter) ||
                     (is_counter && !suppress);

    // Reset gates the write combinationally so a transaction caught in EXEC is dropped.
    assign csr_we        = exec && rst_n && !illegal && !suppress && !is_counter;
    assign bus.csr_we    = csr_we;
    assign bus.csr_addr  = exec ? addr_q : 12'd0;
    assign bus.csr_wdata = csr_we ? new_val : '0;

    assign bus.req_ready    = req_ready_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_rd      = resp_rd_q;
    assign bus.resp_data    = resp_data_q;
    assign bus.resp_illegal = resp_illegal_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            funct3_q       <= 3'd0;
            addr_q         <= 12'd0;
            rs1_q          <= 5'd0;
            rs1_val_q      <= '0;
            rd_q           <= 5'd0;
            req_ready_q    <= 1'b1;
            resp_valid_q   <= 1'b0;
            resp_rd_q      <= 5'd0;
            resp_data_q    <= '0;
            resp_illegal_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        funct3_q    <= bus.req_funct3;
                        addr_q      <= bus.req_addr;
                        rs1_q       <= bus.req_rs1;
                        rs1_val_q   <= bus.req_rs1_val;
                        rd_q        <= bus.req_rd;
                        req_ready_q <= 1'b0;
                        state_q     <= StExec;
                    end
                end
                StExec: begin
                    resp_valid_q   <= 1'b1;
                    resp_rd_q      <= rd_q;
                    resp_data_q    <= illegal ? '0 : old_val;
                    resp_illegal_q <= illegal;
                    state_q        <= StResp;
                end
                StResp: begin
                    if (bus.resp_ready) begin
                        resp_valid_q   <= 1'b0;
                        resp_rd_q      <= 5'd0;
                        resp_data_q    <= '0;
                        resp_illegal_q <= 1'b0;
                        req_ready_q    <= 1'b1;
                        state_q        <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_access_unit.sv
// Bench for csr_access_unit: directed vector table, reset/stall sequences, random ops vs model.
module tb_csr_access_unit;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NCSR = 11;

    typedef struct {
        logic        we;
        logic [31:0] wdata;
        logic [31:0] data;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [4:0]  rs1;
        logic [31:0] val;
        logic [4:0]  rd;
        int          hold;
        exp_t        e;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    csr_access_unit_if #(.XLEN(XLEN)) bus ();

    csr_access_unit #(
        .XLEN(XLEN),
        .NCSR(NCSR)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [31:0]     file_mem  [16] = '{default: 32'h0};
    logic [31:0]     model_mem [16] = '{default: 32'h0};
    int              n_vec      = 0;
    int              n_err      = 0;
    int              n_writes   = 0;
    int              exp_writes = 0;
    longint unsigned cyc        = 0;
    longint unsigned cnt_off    = 0;
    vec_t            vecs [16];
    exp_t            dummy;

    // CSR file behind the port; out-of-range reads return junk the unit must not forward
    always_comb begin
        bus.csr_rdata = 32'hBAD0_BAD0;
        if (bus.csr_addr < 12'd16) bus.csr_rdata = file_mem[bus.csr_addr[3:0]];
    end

    always @(posedge clk) begin
        if (bus.csr_we) begin
            file_mem[bus.csr_addr[3:0]] <= bus.csr_wdata;
            n_writes <= n_writes + 1;
        end
        cyc <= rst_n ? cyc + 64'd1 : 64'd0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Architectural Zicsr semantics; updates the model file on a write.
    function automatic exp_t model(input logic [2:0] f3, input logic [11:0] addr,
                                   input logic [4:0] rs1, input logic [31:0] val,
                                   input longint unsigned cnt);
        exp_t        e;
        int          op     = int'(f3) % 4;
        bit          imm    = (f3 >= 3'd5);
        logic [31:0] src    = imm ? {27'd0, rs1} : val;
        bit          is_cnt = 1'b0;
        bit          writes;
        logic [31:0] old;
        e = '{we: 1'b0, wdata: 32'h0, data: 32'h0, ill: 1'b0};
`ifdef CSR_CYCLE_COUNTER_EN
        is_cnt = (addr == 12'hC00) || (addr == 12'hC80);
`endif
        writes = (op == 1) || (rs1 != 5'd0);
        if (op == 0 || (int'(addr) >= int'(NCSR) && !is_cnt) || (is_cnt && writes)) begin
            e.ill = 1'b1;
            return e;
        end
        if (is_cnt) old = (addr == 12'hC00) ? cnt[31:0] : cnt[63:32];
        else        old = model_mem[addr[3:0]];
        e.data = old;
        if (writes) begin
            e.we    = 1'b1;
            e.wdata = (op == 1) ? src : (op == 2) ? (old | src) : (old & ~src);
            model_mem[addr[3:0]] = e.wdata;
        end
        return e;
    endfunction

    task automatic run_txn(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] rs1,
                           input logic [31:0] val, input logic [4:0] rd, input int hold,
                           input bit use_tbl, input exp_t tbl);
        exp_t e;
        exp_t m;
        int   t = 0;
        @(negedge clk);
        bus.req_valid   = 1'b1;
        bus.req_funct3  = f3;
        bus.req_addr    = addr;
        bus.req_rs1     = rs1;
        bus.req_rs1_val = val;
        bus.req_rd      = rd;
        bus.resp_ready  = 1'b0;
        while (!bus.req_ready && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("req_ready_idle", bus.req_ready, 1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        m = model(f3, addr, rs1, val, cyc + cnt_off);
        e = use_tbl ? tbl : m;
        if (e.we) exp_writes++;
        chk("exec_we", bus.csr_we, e.we);
        chk("exec_wdata", bus.csr_wdata, e.wdata);
        chk("exec_addr", bus.csr_addr, addr);
        chk("exec_req_ready", bus.req_ready, 0);
        chk("exec_resp_valid", bus.resp_valid, 0);
        @(negedge clk);
        for (int h = 0; h <= hold; h++) begin
            chk("resp_valid", bus.resp_valid, 1);
            chk("resp_rd", bus.resp_rd, rd);
            chk("resp_data", bus.resp_data, e.data);
            chk("resp_illegal", bus.resp_illegal, e.ill);
            chk("resp_req_ready", bus.req_ready, 0);
            chk("resp_we", bus.csr_we, 0);
            chk("resp_csr_addr", bus.csr_addr, 0);
            if (h == hold) bus.resp_ready = 1'b1;
            @(negedge clk);
        end
        bus.resp_ready = 1'b0;
        chk("post_req_ready", bus.req_ready, 1);
        chk("post_resp_valid", bus.resp_valid, 0);
    endtask

    initial begin
        dummy = '{we: 1'b0, wdata: 32'h0, data: 32'h0, ill: 1'b0};
        vecs[0]  = '{3'b001, 12'd3,   5'd1,  32'hDEADBEEF, 5'd5,  0, '{1, 32'hDEADBEEF, 32'h0,        0}};
        vecs[1]  = '{3'b010, 12'd3,   5'd2,  32'h0000000F, 5'd6,  5, '{1, 32'hDEADBEEF, 32'hDEADBEEF, 0}};
        vecs[2]  = '{3'b011, 12'd3,   5'd4,  32'hFFFF0000, 5'd7,  0, '{1, 32'h0000BEEF, 32'hDEADBEEF, 0}};
        vecs[3]  = '{3'b111, 12'd3,   5'd0,  32'hFFFFFFFF, 5'd8,  0, '{0, 32'h0,        32'h0000BEEF, 0}};
        vecs[4]  = '{3'b001, 12'd11,  5'd1,  32'h12345678, 5'd9,  0, '{0, 32'h0,        32'h0,        1}};
        vecs[5]  = '{3'b100, 12'd1,   5'd1,  32'h00000001, 5'd10, 0, '{0, 32'h0,        32'h0,        1}};
        vecs[6]  = '{3'b000, 12'd1,   5'd1,  32'h00000001, 5'd10, 1, '{0, 32'h0,        32'h0,        1}};
        vecs[7]  = '{3'b101, 12'd10,  5'h1F, 32'h00000000, 5'd11, 0, '{1, 32'h0000001F, 32'h0,        0}};
        vecs[8]  = '{3'b110, 12'd10,  5'd0,  32'hFFFFFFFF, 5'd12, 0, '{0, 32'h0,        32'h0000001F, 0}};
        vecs[9]  = '{3'b111, 12'd10,  5'd3,  32'hFFFFFFFF, 5'd13, 0, '{1, 32'h0000001C, 32'h0000001F, 0}};
        vecs[10] = '{3'b001, 12'd0,   5'd0,  32'h12345678, 5'd0,  0, '{1, 32'h12345678, 32'h0,        0}};
        vecs[11] = '{3'b010, 12'd0,   5'd0,  32'hFFFFFFFF, 5'd1,  2, '{0, 32'h0,        32'h12345678, 0}};
        vecs[12] = '{3'b001, 12'hC00, 5'd1,  32'h00000005, 5'd2,  0, '{0, 32'h0,        32'h0,        1}};
        vecs[13] = '{3'b010, 12'hC80, 5'd3,  32'h00000001, 5'd3,  0, '{0, 32'h0,        32'h0,        1}};
        vecs[14] = '{3'b110, 12'd3,   5'h10, 32'h00000000, 5'd31, 0, '{1, 32'h0000BEFF, 32'h0000BEEF, 0}};
        vecs[15] = '{3'b010, 12'hFFF, 5'd1,  32'h00000001, 5'd4,  0, '{0, 32'h0,        32'h0,        1}};

        bus.req_valid   = 1'b0;
        bus.req_funct3  = 3'd0;
        bus.req_addr    = 12'd0;
        bus.req_rs1     = 5'd0;
        bus.req_rs1_val = 32'h0;
        bus.req_rd      = 5'd0;
        bus.resp_ready  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_data", bus.resp_data, 0);
        chk("rst_resp_illegal", bus.resp_illegal, 0);
        chk("rst_csr_we", bus.csr_we, 0);
        chk("rst_csr_addr", bus.csr_addr, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_txn(vecs[i].f3, vecs[i].addr, vecs[i].rs1, vecs[i].val, vecs[i].rd,
                    vecs[i].hold, 1'b1, vecs[i].e);
        end

        // Reset while in EXEC drops the write and the response.
        @(negedge clk);
        bus.req_valid   = 1'b1;
        bus.req_funct3  = 3'b001;
        bus.req_addr    = 12'd2;
        bus.req_rs1     = 5'd1;
        bus.req_rs1_val = 32'hA5A5A5A5;
        bus.req_rd      = 5'd7;
        bus.resp_ready  = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("rexec_we_before", bus.csr_we, 1);
        rst_n = 1'b0;
        #1;
        chk("rexec_we_forced", bus.csr_we, 0);
        chk("rexec_wdata_forced", bus.csr_wdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rexec_idle_ready", bus.req_ready, 1);
        for (int i = 0; i < 3; i++) begin
            chk("rexec_no_resp", bus.resp_valid, 0);
            @(negedge clk);
        end
        bus.resp_ready = 1'b0;
        chk("rexec_file2", file_mem[2], model_mem[2]);

`ifdef CSR_CYCLE_COUNTER_EN
        run_txn(3'b010, 12'hC00, 5'd0, 32'h0, 5'd3, 0, 1'b0, dummy);
        run_txn(3'b011, 12'hC80, 5'd0, 32'h0, 5'd4, 0, 1'b0, dummy);
        run_txn(3'b001, 12'hC00, 5'd1, 32'h5, 5'd4, 0, 1'b0, dummy);
        @(negedge clk);
        dut.cycle_q = 64'hFFFF_FFFF_FFFF_FFFE;
        cnt_off     = 64'hFFFF_FFFF_FFFF_FFFE - cyc;
        run_txn(3'b010, 12'hC00, 5'd0, 32'h0, 5'd5, 0, 1'b0, dummy);
        run_txn(3'b010, 12'hC80, 5'd0, 32'h0, 5'd6, 0, 1'b0, dummy);
`endif

        for (int i = 0; i < 150; i++) begin
            logic [2:0]  f3;
            logic [11:0] addr;
            logic [4:0]  rs1;
            f3   = 3'($urandom_range(0, 7));
            addr = 12'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) addr = ($urandom_range(0, 1) == 0) ? 12'hC00 : 12'hC80;
            rs1  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            run_txn(f3, addr, rs1, $urandom, 5'($urandom), $urandom_range(0, 2), 1'b0, dummy);
        end

        for (int i = 0; i < int'(NCSR); i++) chk("final_file", file_mem[i], model_mem[i]);
        chk("write_count", 64'(n_writes), 64'(exp_writes));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
